// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, stall-cause
// priority and the per-stage stall/flush bundle each cause produces.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_e;
  typedef enum logic [1:0] {F_READY = 2'd0, F_WAIT = 2'd1, F_DROP = 2'd2} fetch_state_e;

  // Declared in priority order: a lower value wins when several causes are active.
  typedef enum logic [2:0] {
    C_EXC = 3'd0, C_DATA = 3'd1, C_MD = 3'd2, C_HAZ = 3'd3, C_FETCH = 3'd4, C_NONE = 3'd7
  } stall_cause_e;

  typedef struct packed {
    logic stall_if, stall_id, stall_ex, stall_mm;
    logic flush_id, flush_ex, flush_mm, flush_wb;
  } ctrl_t;

  // Only the winning cause drives the stages, so a stage held by it can
  // never be bubbled by a weaker cause. The exception still lets a
  // dropping fetch hold IF.
  function automatic ctrl_t cause_ctrl(input stall_cause_e c, input logic fetch_hold);
    ctrl_t r;
    r = '0;
    case (c)
      C_EXC:   begin r.stall_if = fetch_hold; r.flush_id = 1'b1; r.flush_ex = 1'b1; r.flush_mm = 1'b1; end
      C_DATA:  begin r.stall_if = 1'b1; r.stall_id = 1'b1; r.stall_ex = 1'b1; r.stall_mm = 1'b1; r.flush_wb = 1'b1; end
      C_MD:    begin r.stall_if = 1'b1; r.stall_id = 1'b1; r.stall_ex = 1'b1; r.flush_mm = 1'b1; end
      C_HAZ:   begin r.stall_if = 1'b1; r.stall_id = 1'b1; r.flush_ex = 1'b1; end
      C_FETCH: begin r.stall_if = 1'b1; r.flush_id = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the core stages and the pipeline sequencer.
interface pipe_ctrl_if #(parameter int PC_W = 32, parameter int PERF_W = 32);
  logic              hazard_stall;
  logic              muldiv_req, muldiv_done, muldiv_start, muldiv_abort;
  logic              inst_req, inst_ok, inst_drop;
  logic              data_req, data_ok;
  logic              exc_valid;
  logic [PC_W-1:0]   exc_target;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              stall_if, stall_id, stall_ex, stall_mm;
  logic              flush_id, flush_ex, flush_mm, flush_wb;
  logic              perf_clr;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output hazard_stall, muldiv_req, muldiv_done, inst_req, inst_ok,
           data_req, data_ok, exc_valid, exc_target, perf_clr,
    input  muldiv_start, muldiv_abort, inst_drop, redirect_valid, redirect_pc,
           stall_if, stall_id, stall_ex, stall_mm,
           flush_id, flush_ex, flush_mm, flush_wb, stall_cycles
  );

  modport slave (
    input  hazard_stall, muldiv_req, muldiv_done, inst_req, inst_ok,
           data_req, data_ok, exc_valid, exc_target, perf_clr,
    output muldiv_start, muldiv_abort, inst_drop, redirect_valid, redirect_pc,
           stall_if, stall_id, stall_ex, stall_mm,
           flush_id, flush_ex, flush_mm, flush_wb, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_fetch.sv
// Tracks the single outstanding instruction fetch and discards the one
// that was in flight when an exception redirected the PC.
module pipe_ctrl_fetch
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_inst_req,
  input  logic i_inst_ok,
  input  logic i_exc_valid,
  output logic o_fetch_wait,
  output logic o_inst_drop
);

  fetch_state_e r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= F_READY;
    end else begin
      case (r_state)
        F_READY: if (i_inst_req) r_state <= F_WAIT;
        F_WAIT: begin
          if (i_exc_valid)                  r_state <= i_inst_ok ? F_READY : F_DROP;
          else if (i_inst_ok && !i_inst_req) r_state <= F_READY;
        end
        F_DROP:  if (i_inst_ok) r_state <= F_READY;
        default: r_state <= F_READY;
      endcase
    end
  end

  // DROP holds IF even in the cycle the stale data lands.
  assign o_fetch_wait = (r_state == F_WAIT && !i_inst_ok) || (r_state == F_DROP);
  assign o_inst_drop  = i_inst_ok && ((r_state == F_WAIT && i_exc_valid) || r_state == F_DROP);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall sources into per-stage stall/flush,
// runs the mul/div handshake and counts IF stall cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PERF_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  pipe_ctrl_if.slave bus
);

  md_state_e         r_md;
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PC_W-1:0]   w_redirect_pc;
  logic              w_fetch_wait, w_inst_drop, w_data_wait, w_md_hold;
  stall_cause_e      w_cause;
  ctrl_t             w_ctrl;

  pipe_ctrl_fetch u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inst_req   (bus.inst_req),
    .i_inst_ok    (bus.inst_ok),
    .i_exc_valid  (bus.exc_valid),
    .o_fetch_wait (w_fetch_wait),
    .o_inst_drop  (w_inst_drop)
  );

  assign w_data_wait = bus.data_req && !bus.data_ok;
  // The done cycle already releases EX; DONE itself never holds.
  assign w_md_hold   = (r_md == MD_BUSY && !bus.muldiv_done) || (r_md == MD_IDLE && bus.muldiv_req);

  always_comb begin
    w_cause = C_NONE;
    if (bus.exc_valid)       w_cause = C_EXC;
    else if (w_data_wait)    w_cause = C_DATA;
    else if (w_md_hold)      w_cause = C_MD;
    else if (bus.hazard_stall) w_cause = C_HAZ;
    else if (w_fetch_wait)   w_cause = C_FETCH;
  end

  assign w_ctrl        = cause_ctrl(w_cause, w_fetch_wait);
  assign w_redirect_pc = bus.exc_valid ? bus.exc_target : '0;

  assign bus.stall_if       = w_ctrl.stall_if;
  assign bus.stall_id       = w_ctrl.stall_id;
  assign bus.stall_ex       = w_ctrl.stall_ex;
  assign bus.stall_mm       = w_ctrl.stall_mm;
  assign bus.flush_id       = w_ctrl.flush_id;
  assign bus.flush_ex       = w_ctrl.flush_ex;
  assign bus.flush_mm       = w_ctrl.flush_mm;
  assign bus.flush_wb       = w_ctrl.flush_wb;
  assign bus.redirect_valid = bus.exc_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.inst_drop      = w_inst_drop;
  assign bus.muldiv_start   = (r_md == MD_IDLE) && bus.muldiv_req && !bus.exc_valid;
  assign bus.muldiv_abort   = (r_md == MD_BUSY) && bus.exc_valid;
  assign bus.stall_cycles   = r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md <= MD_IDLE;
    end else begin
      case (r_md)
        MD_IDLE: if (bus.muldiv_req && !bus.exc_valid) r_md <= MD_BUSY;
        MD_BUSY: begin
          if (bus.exc_valid)        r_md <= MD_IDLE;
          else if (bus.muldiv_done) r_md <= MD_DONE;
        end
        // Wait for EX to move on so the same instruction is not relaunched.
        MD_DONE: if (bus.exc_valid || !w_ctrl.stall_ex) r_md <= MD_IDLE;
        default: r_md <= MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_stall_cycles <= '0;
    else if (bus.perf_clr)                           r_stall_cycles <= '0;
    else if (w_ctrl.stall_if && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboarded bench for pipe_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int PC_W   = 32;
  localparam int PERF_W = 6;
  localparam logic [PERF_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.PC_W(PC_W), .PERF_W(PERF_W)) bus ();
  pipe_ctrl #(.PC_W(PC_W), .PERF_W(PERF_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic hz, mreq, mdone, ireq, iok, dreq, dok, exc, clr;
    logic [PC_W-1:0] tgt;
  } stim_t;

  // sf = {stall_if, stall_id, stall_ex, stall_mm, flush_id, flush_ex, flush_mm, flush_wb}
  typedef struct packed {
    logic mstart, mabort, idrop, redir;
    logic [PC_W-1:0] rpc;
    logic [7:0] sf;
    logic [PERF_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;

  // model state: what the unit is doing, not how it encodes it
  bit mul_running, mul_finished, fetch_pending, fetch_discard;
  logic [PERF_W-1:0] cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mul_running = 0; mul_finished = 0; fetch_pending = 0; fetch_discard = 0; cnt = '0;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit d_wait, md_hold, f_hold, stall_ex;
    d_wait  = s.dreq && !s.dok;
    md_hold = (mul_running && !s.mdone) || (!mul_running && !mul_finished && s.mreq);
    f_hold  = (fetch_pending && !s.iok) || fetch_discard;
    e = '0;
    if (s.exc) begin
      e.sf = {f_hold, 7'b000_1110};
      e.redir = 1'b1;
      e.rpc = s.tgt;
    end
    else if (d_wait)  e.sf = 8'b1111_0001;
    else if (md_hold) e.sf = 8'b1110_0010;
    else if (s.hz)    e.sf = 8'b1100_0100;
    else if (f_hold)  e.sf = 8'b1000_1000;
    stall_ex = e.sf[5];
    e.mstart = !mul_running && !mul_finished && s.mreq && !s.exc;
    e.mabort = mul_running && s.exc;
    e.idrop  = s.iok && (fetch_discard || (fetch_pending && s.exc));
    e.cnt    = cnt;
    if (mul_running) begin
      if (s.exc) mul_running = 0;
      else if (s.mdone) begin mul_running = 0; mul_finished = 1; end
    end else if (mul_finished) begin
      if (s.exc || !stall_ex) mul_finished = 0;
    end else if (e.mstart) mul_running = 1;
    if (fetch_discard) begin
      if (s.iok) fetch_discard = 0;
    end else if (fetch_pending) begin
      if (s.exc) begin fetch_pending = 0; fetch_discard = !s.iok; end
      else if (s.iok) fetch_pending = s.ireq;
    end else if (s.ireq) fetch_pending = 1;
    if (s.clr) cnt = '0;
    else if (e.sf[7] && cnt != CNT_MAX) cnt = cnt + 1'b1;
  endtask

  task automatic apply(input stim_t s);
    bus.hazard_stall = s.hz;  bus.muldiv_req = s.mreq; bus.muldiv_done = s.mdone;
    bus.inst_req = s.ireq;    bus.inst_ok = s.iok;     bus.data_req = s.dreq;
    bus.data_ok = s.dok;      bus.exc_valid = s.exc;   bus.perf_clr = s.clr;
    bus.exc_target = s.tgt;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    apply(s);
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.hz    = ($urandom_range(0, 3) == 0);
    s.mreq  = ($urandom_range(0, 2) == 0);
    s.mdone = ($urandom_range(0, 3) == 0);
    s.dreq  = ($urandom_range(0, 2) == 0);
    s.dok   = ($urandom_range(0, 1) == 0);
    s.exc   = ($urandom_range(0, 9) == 0);
    s.clr   = ($urandom_range(0, 29) == 0);
    s.tgt   = $urandom;
    s.iok   = (fetch_pending || fetch_discard) ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (fetch_discard)      s.ireq = 1'b0;
    else if (fetch_pending) s.ireq = s.iok && !s.exc && ($urandom_range(0, 1) == 0);
    else                    s.ireq = ($urandom_range(0, 1) == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("stall_flush", {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mm,
                          bus.flush_id, bus.flush_ex, bus.flush_mm, bus.flush_wb}, mon_e.sf);
      chk("muldiv_start", bus.muldiv_start, mon_e.mstart);
      chk("muldiv_abort", bus.muldiv_abort, mon_e.mabort);
      chk("inst_drop", bus.inst_drop, mon_e.idrop);
      chk("redirect_valid", bus.redirect_valid, mon_e.redir);
      chk("redirect_pc", bus.redirect_pc, mon_e.rpc);
      chk("stall_cycles", bus.stall_cycles, mon_e.cnt);
    end
  end

  initial begin
    stim_t s;
    apply('0);
    model_reset();
    #22;
    chk("reset_ctrl", {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mm, bus.flush_id,
                       bus.flush_ex, bus.flush_mm, bus.flush_wb, bus.redirect_valid,
                       bus.muldiv_start, bus.muldiv_abort, bus.inst_drop}, 0);
    chk("reset_cnt", bus.stall_cycles, 0);
    @(negedge clk) rst_n = 1'b1;

    // single-cycle hazard
    s = '0; s.clr = 1; drive(s);
    s = '0; s.hz = 1;  drive(s);
    drive('0);
    chk("haz_cnt", bus.stall_cycles, 1);

    // mul/div: start in cycle 0, done in cycle 5
    s = '0; s.clr = 1; drive(s);
    for (int i = 0; i < 6; i++) begin
      s = '0; s.mreq = 1; s.mdone = (i == 5);
      drive(s);
      if (i == 0) begin #1; chk("md_start_c0", bus.muldiv_start, 1); end
      if (i == 5) begin #1; chk("md_release", bus.stall_ex, 0); end
    end
    drive('0);
    chk("md_cnt", bus.stall_cycles, 5);

    // abort in BUSY
    s = '0; s.mreq = 1; drive(s); drive(s);
    s.exc = 1; s.tgt = 32'hBFC0_0380; drive(s);
    #1;
    chk("abort_pulse", bus.muldiv_abort, 1);
    chk("abort_pc", bus.redirect_pc, 32'hBFC0_0380);
    drive('0); drive('0);

    // fetch redirected while outstanding
    s = '0; s.ireq = 1; drive(s);
    drive('0);
    s = '0; s.exc = 1; s.tgt = 32'h0000_1000; drive(s);
    drive('0); drive('0);
    s = '0; s.iok = 1; drive(s);
    #1; chk("drop_pulse", bus.inst_drop, 1);
    drive('0);

    // data wait masks hazard until data_ok
    for (int i = 0; i < 5; i++) begin
      s = '0; s.dreq = 1; s.hz = 1; s.dok = (i == 4);
      drive(s);
      if (i == 1) begin #1; chk("dwait_no_flush_ex", {bus.flush_ex, bus.flush_wb, bus.stall_mm}, 3'b011); end
      if (i == 4) begin #1; chk("haz_after_ok", {bus.flush_ex, bus.stall_mm}, 2'b10); end
    end
    drive('0);

    // saturation then clear while stalled
    s = '0; s.clr = 1; drive(s);
    s = '0; s.hz = 1;
    repeat (70) drive(s);
    chk("sat_cnt", bus.stall_cycles, CNT_MAX);
    s.clr = 1; drive(s);
    s.clr = 0; drive(s);
    chk("clr_cnt", bus.stall_cycles, 0);
    drive('0);
    chk("inc_after_clr", bus.stall_cycles, 1);

    // reset while a mul/div is in flight: no abort, everything cleared
    s = '0; s.mreq = 1; drive(s); drive(s);
    #1;
    rst_n = 1'b0;
    apply('0);
    exp_q.delete();
    model_reset();
    #2;
    chk("midrst_abort", bus.muldiv_abort, 0);
    chk("midrst_cnt", bus.stall_cycles, 0);
    chk("midrst_stall", bus.stall_if, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) drive(rand_stim());
    drive('0); drive('0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF/ID/EX/MM/WB).
- Merges stall sources into one consistent set of per-stage stall/flush controls:
  - hazard stall from the forwarding unit;
  - multi-cycle mul/div occupancy;
  - instruction-bus and data-bus wait states;
  - exceptions raised in MM.
- Owns the mul/div start/abort handshake and the dropping of in-flight fetches after a redirect.
- Keeps a stall-cycle performance counter.

Parameters:
- PC_W, 32, width of redirect target.
- PERF_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hazard_stall  in  1  ID-stage stall request from the forwarding unit.
- muldiv_req  in  1  EX holds a mul/div instruction.
- muldiv_done  in  1  mul/div result valid (single-cycle pulse).
- muldiv_start  out  1  one-cycle launch pulse to the mul/div unit.
- muldiv_abort  out  1  one-cycle cancel pulse to the mul/div unit.
- inst_req  in  1  IF issues a fetch this cycle.
- inst_ok  in  1  fetch data returned.
- inst_drop  out  1  IF must discard the data returned this cycle.
- data_req  in  1  MM holds a load/store whose bus access is outstanding.
- data_ok  in  1  data bus completes the access.
- exc_valid  in  1  MM instruction raises an exception.
- exc_target  in  PC_W  handler address.
- redirect_valid  out  1  load redirect_pc into the PC; overrides stall_if.
- redirect_pc  out  PC_W  new PC.
- stall_if, stall_id, stall_ex, stall_mm  out  1 each  hold the stage register.
- flush_id, flush_ex, flush_mm, flush_wb  out  1 each  insert a bubble into the stage register.
- perf_clr  in  1  synchronous clear of the counter.
- stall_cycles  out  PERF_W  number of cycles with stall_if=1, saturating.

Behaviour:
- Reset: all outputs 0; both FSMs to their idle states; stall_cycles=0. Reset mid-operation abandons any outstanding bus or mul/div transaction with no abort pulse.
- Stall/flush outputs are combinational from inputs and registered state. Zero-cycle latency.
- Stall priority, highest first (the first matching term wins):
  1. Exception: exc_valid → flush_id=flush_ex=flush_mm=1, redirect_valid=1, redirect_pc=exc_target, and no stalls except fetch-drop. data_req is ignored in that cycle.
  2. Data wait: data_req & !data_ok → stall_if..stall_mm=1, flush_wb=1.
  3. Mul/div busy: MD state BUSY, or muldiv_req in IDLE → stall_if/id/ex=1, flush_mm=1.
  4. Hazard: hazard_stall → stall_if/id=1, flush_ex=1.
  5. Fetch wait: fetch state WAIT & !inst_ok, or fetch state DROP → stall_if=1, flush_id=1.
- A stage that is stalled by a higher term is never flushed by a lower term.
- MD FSM:
  - IDLE: muldiv_req & !exc_valid → muldiv_start=1, go to BUSY.
  - BUSY: muldiv_done → go to DONE; stall released in the same cycle only if no higher term holds EX.
  - DONE: hold the result until !stall_ex, then go to IDLE. No restart while EX still holds the same instruction.
  - Abort: exc_valid in BUSY or DONE → muldiv_abort=1 when in BUSY, go to IDLE.
  - muldiv_done outside BUSY is ignored.
- Fetch FSM:
  - READY: inst_req → go to WAIT.
  - WAIT:
    - inst_ok & !exc_valid → go to READY, or stay in WAIT if inst_req is also high (back-to-back).
    - exc_valid & !inst_ok → go to DROP.
    - exc_valid & inst_ok → inst_drop=1, go to READY.
  - DROP: inst_ok → inst_drop=1, go to READY. inst_req is illegal in DROP; IF is stalled.
- Counter: +1 per stall_if cycle. Saturates at all-ones. perf_clr wins over increment.

Decomposition:
- Shared package (the datapath defines file) holds the state encodings for MD_IDLE/MD_BUSY/MD_DONE and F_READY/F_WAIT/F_DROP, and the stall-cause priority constants.
- One sub-module, pipe_ctrl_fetch, isolates the fetch WAIT/DROP FSM and inst_drop generation.

Test Plan:
- hazard_stall=1 for 1 cycle, all else idle → stall_if=stall_id=1 and flush_ex=1 for exactly that cycle; stall_cycles=1.
- muldiv_req=1 with muldiv_done after 5 cycles →
  - muldiv_start pulses once in cycle 0;
  - stall_ex=1 for cycles 0-4, low in cycle 5 (done cycle);
  - stall_cycles=5.
- muldiv in BUSY, exc_valid=1 with exc_target=0xBFC00380 →
  - muldiv_abort=1;
  - flush_id/ex/mm=1;
  - redirect_pc=0xBFC00380;
  - MD back to IDLE next cycle with no second start.
- inst_req then exc_valid 2 cycles later with inst_ok 3 cycles after that → DROP state; stall_if=1 until inst_ok; inst_drop=1 in the inst_ok cycle only.
- data_req held 4 cycles alongside hazard_stall=1 → stall_if..stall_mm=1 and flush_wb=1 while the access is pending; flush_ex stays 0; hazard term applies only after data_ok.
- Counter preset to all-ones by long stall, then perf_clr with stall active → stall_cycles=0 next cycle, then increments.
